sync_fifo_prog: RTL and testbench
=================================

# sync_fifo_prog

Parametrised synchronous FIFO that succeeds the fixed 16x8 FIFO used throughout the verification environment. It adds arbitrary (non-power-of-two) depth, a selectable first-word-fall-through (FWFT) read mode, runtime-programmable almost-full and almost-empty thresholds, a synchronous flush, and a read-valid strobe. It is the buffering primitive for the next-generation datapath and its UVM environment.

## Interface
- DATA_WIDTH, 16, width of data_in/data_out
- DEPTH, 8, number of entries; any integer >= 2 (not restricted to powers of two)
- FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through
- CW (localparam), $clog2(DEPTH+1), width of count and thresholds
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- wr_en  in  1  write request
- data_in  in  DATA_WIDTH  write data
- rd_en  in  1  read (pop) request
- flush  in  1  synchronous clear of contents
- af_thresh  in  CW  almost-full threshold
- ae_thresh  in  CW  almost-empty threshold
- data_out  out  DATA_WIDTH  read data
- rd_valid  out  1  data_out holds valid read data
- wr_ack  out  1  previous-cycle write accepted
- overflow  out  1  previous-cycle write rejected (full)
- underflow  out  1  previous-cycle read rejected (empty)
- full, empty, almostfull, almostempty  out  1 each  status flags
- count  out  CW  current occupancy, 0..DEPTH

## Operation
- Storage: DEPTH x DATA_WIDTH array. wr_ptr and rd_ptr range 0..DEPTH-1 and wrap explicitly: DEPTH-1 -> 0 (no reliance on natural binary overflow).
- Accepted write: wr_en && (!full || rd_en). Accepted read: rd_en && !empty.
- Full with wr_en && rd_en: both are accepted, count is unchanged, and the slot freed by the read is refilled.
- Empty with wr_en && rd_en: only the write is accepted, count becomes +1, and the read flags underflow.
- count: +1 on write-only, -1 on read-only, unchanged on both or neither. It never exceeds DEPTH and never drops below 0.
- Flags (combinational from count):
  - full = (count == DEPTH)
  - empty = (count == 0)
  - almostfull = (count >= af_thresh)
  - almostempty = (count <= ae_thresh)
  - With af_thresh = 0, almostfull is held at 1. With ae_thresh >= DEPTH, almostempty is held at 1. Thresholds may change on any cycle and take effect combinationally.
- Registered strobes:
  - wr_ack = 1 the cycle after an accepted write, else 0.
  - overflow = 1 the cycle after wr_en that was not accepted, else 0.
  - underflow = 1 the cycle after rd_en while empty, else 0.
- FWFT = 0: on an accepted read, data_out <= mem[rd_ptr] and rd_valid <= 1. Otherwise rd_valid <= 0 and data_out holds its value.
- FWFT = 1: data_out = mem[rd_ptr] combinationally and rd_valid = !empty. rd_en acknowledges (pops) the displayed word.
- flush: takes priority over wr_en and rd_en in the same cycle. It sets wr_ptr, rd_ptr and count to 0, and clears wr_ack, overflow, underflow and the registered rd_valid. data_out holds (FWFT = 0). Memory contents are not cleared.
- Reset: rst_n = 0 sampled at a clock edge has the same effect as flush and additionally clears data_out to 0. Reset overrides flush. Reset asserted mid-stream discards all contents at that edge.

## Timing
- Write latency: data is visible to a read on the cycle after the accepted write. In FWFT mode, data_out/rd_valid update one cycle after the first write into an empty FIFO.
- Read latency:
  - FWFT = 0: data_out/rd_valid one cycle after rd_en.
  - FWFT = 1: zero cycles (word is already presented).
- All status flags reflect count after the most recent edge, with no extra pipeline stage.
- Reset values after the first clock edge with rst_n = 0:
  - count = 0, empty = 1, full = 0, almostfull = (af_thresh == 0), almostempty = 1
  - wr_ack = overflow = underflow = rd_valid = 0, data_out = 0
- Before the first clock edge, outputs are undefined.
- Throughput: one write and one read per cycle, sustained.

## Test plan
- DEPTH = 6, FWFT = 0, reset then write 0x0001..0x0006 -> wr_ack high 6 cycles, full = 1 and count = 6 after the 6th edge. A 7th write -> overflow = 1 the next cycle and count stays 6.
- Same FIFO, read 7 times -> data_out 0x0001..0x0006 in order with rd_valid = 1 each time. The 7th read -> underflow = 1, rd_valid = 0, empty = 1.
- Wrap-around, DEPTH = 6: 20 interleaved single writes and reads with data = index -> data_out always equals index, and no pointer value 6 or 7 is ever reached.
- Simultaneous events:
  - Full with wr_en = rd_en = 1 -> count stays 6, wr_ack = 1, overflow = 0.
  - Empty with both -> count = 1, underflow = 1, wr_ack = 1.
- Thresholds: af_thresh = 5, ae_thresh = 1, fill 0..6 -> almostfull at count >= 5 and almostempty at count <= 1. Change af_thresh to 3 at count 4 -> almostfull rises in the same cycle.
- FWFT = 1: write 0xBEEF into empty -> next cycle data_out = 0xBEEF and rd_valid = 1 with no rd_en. Flush with wr_en = 1 on the same cycle -> count = 0, rd_valid = 0, wr_ack = 0. Reset mid-fill (count = 3) -> all outputs at reset values after the edge.

Source files
------------

// File: rtl/sync_fifo_prog_if.sv
// rtl/sync_fifo_prog_if.sv - Handshake/status bundle for sync_fifo_prog
//
// Purpose: groups the write, read, control and status signals of the
// programmable FIFO so producer/consumer and FIFO connect through one port.
// Signals (master = user side drives, slave = FIFO side drives):
//   wr_en, data_in            write request and data            (master)
//   rd_en                     read / pop request                (master)
//   flush                     synchronous clear of contents     (master)
//   af_thresh, ae_thresh      almost-full / almost-empty levels (master)
//   data_out, rd_valid        read data and its valid flag      (slave)
//   wr_ack, overflow          previous-cycle write accepted / rejected (slave)
//   underflow                 previous-cycle read rejected      (slave)
//   full, empty               occupancy limits                  (slave)
//   almostfull, almostempty   threshold flags                   (slave)
//   count                     current occupancy 0..DEPTH        (slave)
interface sync_fifo_prog_if #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  rd_en;
  logic                  flush;
  logic [CW-1:0]         af_thresh;
  logic [CW-1:0]         ae_thresh;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  rd_valid;
  logic                  wr_ack;
  logic                  overflow;
  logic                  underflow;
  logic                  full;
  logic                  empty;
  logic                  almostfull;
  logic                  almostempty;
  logic [CW-1:0]         count;

  modport master (
    output wr_en, data_in, rd_en, flush, af_thresh, ae_thresh,
    input  data_out, rd_valid, wr_ack, overflow, underflow,
           full, empty, almostfull, almostempty, count
  );

  modport slave (
    input  wr_en, data_in, rd_en, flush, af_thresh, ae_thresh,
    output data_out, rd_valid, wr_ack, overflow, underflow,
           full, empty, almostfull, almostempty, count
  );
endinterface

// File: rtl/sync_fifo_prog.sv
// rtl/sync_fifo_prog.sv - Synchronous FIFO with arbitrary depth, FWFT option and programmable thresholds
//
// Purpose: DEPTH x DATA_WIDTH buffer. Pointers wrap explicitly at DEPTH-1 so
// any DEPTH >= 2 works. FWFT = 0 gives a registered read (data one cycle after
// rd_en); FWFT = 1 presents the head word combinationally and rd_en pops it.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset (overrides flush)
//   bus    sync_fifo_prog_if.slave: write/read/flush/thresholds in,
//          data_out, rd_valid, strobes, flags and count out
module sync_fifo_prog #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int FWFT       = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  sync_fifo_prog_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  wr_ack_q, overflow_q, underflow_q;
  logic                  full, empty;
  logic                  wr_accept, rd_accept;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // A write into a full FIFO still goes through when a read frees a slot
  // in the same cycle.
  assign wr_accept = bus.wr_en && (!full || bus.rd_en);
  assign rd_accept = bus.rd_en && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_accept) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (rd_accept) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n || bus.flush) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      wr_ack_q    <= wr_accept;
      overflow_q  <= bus.wr_en && !wr_accept;
      underflow_q <= bus.rd_en && empty;
    end
  end

  // Storage is never cleared; a flush or reset only rewinds the pointers.
  always_ff @(posedge clk) begin
    if (rst_n && !bus.flush && wr_accept) mem_q[wr_ptr_q] <= bus.data_in;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is shown directly; zero is presented while empty so the
      // output reads as 0 after reset regardless of stale storage.
      assign bus.data_out = empty ? '0 : mem_q[rd_ptr_q];
      assign bus.rd_valid = !empty;
    end else begin : g_std
      logic [DATA_WIDTH-1:0] data_out_q;
      logic                  rd_valid_q;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          data_out_q <= '0;
          rd_valid_q <= 1'b0;
        end else if (bus.flush) begin
          rd_valid_q <= 1'b0;
        end else begin
          rd_valid_q <= rd_accept;
          if (rd_accept) data_out_q <= mem_q[rd_ptr_q];
        end
      end

      assign bus.data_out = data_out_q;
      assign bus.rd_valid = rd_valid_q;
    end
  endgenerate

  assign bus.wr_ack      = wr_ack_q;
  assign bus.overflow    = overflow_q;
  assign bus.underflow   = underflow_q;
  assign bus.full        = full;
  assign bus.empty       = empty;
  assign bus.almostfull  = (count_q >= bus.af_thresh);
  assign bus.almostempty = (count_q <= bus.ae_thresh);
  assign bus.count       = count_q;
endmodule

// File: tb/tb_sync_fifo_prog.sv
// tb/tb_sync_fifo_prog.sv - Directed self-checking bench for sync_fifo_prog (registered and FWFT)
module tb_sync_fifo_prog;
  localparam int DW = 16;
  localparam int DP = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sync_fifo_prog_if #(.DATA_WIDTH(DW), .DEPTH(DP)) bus0 ();
  sync_fifo_prog_if #(.DATA_WIDTH(DW), .DEPTH(DP)) bus1 ();

  sync_fifo_prog #(.DATA_WIDTH(DW), .DEPTH(DP), .FWFT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave));
  sync_fifo_prog #(.DATA_WIDTH(DW), .DEPTH(DP), .FWFT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle0();
    bus0.wr_en = 1'b0; bus0.rd_en = 1'b0; bus0.flush = 1'b0;
  endtask

  initial begin
    bus0.wr_en = 0; bus0.rd_en = 0; bus0.flush = 0; bus0.data_in = '0;
    bus0.af_thresh = 3'd0; bus0.ae_thresh = 3'd1;
    bus1.wr_en = 0; bus1.rd_en = 0; bus1.flush = 0; bus1.data_in = '0;
    bus1.af_thresh = 3'd4; bus1.ae_thresh = 3'd1;

    // reset state
    rst_n = 1'b0;
    tick(); tick();
    chk("rst_count", 32'(bus0.count), 0);
    chk("rst_empty", 32'(bus0.empty), 1);
    chk("rst_full", 32'(bus0.full), 0);
    chk("rst_af_thr0", 32'(bus0.almostfull), 1);
    chk("rst_ae", 32'(bus0.almostempty), 1);
    chk("rst_wr_ack", 32'(bus0.wr_ack), 0);
    chk("rst_ovf", 32'(bus0.overflow), 0);
    chk("rst_udf", 32'(bus0.underflow), 0);
    chk("rst_rd_valid", 32'(bus0.rd_valid), 0);
    chk("rst_data_out", 32'(bus0.data_out), 0);
    chk("rst_fwft_data", 32'(bus1.data_out), 0);
    chk("rst_fwft_valid", 32'(bus1.rd_valid), 0);
    bus0.af_thresh = 3'd5;
    rst_n = 1'b1;

    // fill 1..6 with threshold checks (af=5, ae=1)
    for (int i = 1; i <= 6; i++) begin
      bus0.wr_en = 1'b1; bus0.data_in = 16'(i);
      tick();
      chk("fill_wr_ack", 32'(bus0.wr_ack), 1);
      chk("fill_count", 32'(bus0.count), 32'(i));
      chk("fill_af", 32'(bus0.almostfull), (i >= 5) ? 1 : 0);
      chk("fill_ae", 32'(bus0.almostempty), (i <= 1) ? 1 : 0);
      if (i == 4) begin
        bus0.af_thresh = 3'd3;
        #1;
        chk("af_thresh_change", 32'(bus0.almostfull), 1);
        bus0.af_thresh = 3'd5;
        #1;
        chk("af_thresh_restore", 32'(bus0.almostfull), 0);
      end
    end
    chk("fill_full", 32'(bus0.full), 1);

    // 7th write overflows
    bus0.data_in = 16'h0007;
    tick();
    chk("ovf_flag", 32'(bus0.overflow), 1);
    chk("ovf_wr_ack", 32'(bus0.wr_ack), 0);
    chk("ovf_count", 32'(bus0.count), 6);
    idle0();

    // drain 7 times
    for (int k = 1; k <= 7; k++) begin
      bus0.rd_en = 1'b1;
      tick();
      if (k <= 6) begin
        chk("rd_data", 32'(bus0.data_out), 32'(k));
        chk("rd_valid", 32'(bus0.rd_valid), 1);
        chk("rd_count", 32'(bus0.count), 32'(6 - k));
        chk("rd_no_udf", 32'(bus0.underflow), 0);
      end else begin
        chk("udf_flag", 32'(bus0.underflow), 1);
        chk("udf_rd_valid", 32'(bus0.rd_valid), 0);
        chk("udf_empty", 32'(bus0.empty), 1);
        chk("udf_data_hold", 32'(bus0.data_out), 6);
      end
    end

    // empty with both
    bus0.wr_en = 1'b1; bus0.rd_en = 1'b1; bus0.data_in = 16'h00AA;
    tick();
    chk("both_empty_count", 32'(bus0.count), 1);
    chk("both_empty_udf", 32'(bus0.underflow), 1);
    chk("both_empty_ack", 32'(bus0.wr_ack), 1);
    chk("both_empty_valid", 32'(bus0.rd_valid), 0);
    bus0.rd_en = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      bus0.data_in = 16'(16'h00B0 + i);
      tick();
    end
    chk("refill_count", 32'(bus0.count), 6);

    // full with both
    bus0.rd_en = 1'b1; bus0.data_in = 16'h00CC;
    tick();
    chk("both_full_count", 32'(bus0.count), 6);
    chk("both_full_ack", 32'(bus0.wr_ack), 1);
    chk("both_full_ovf", 32'(bus0.overflow), 0);
    chk("both_full_data", 32'(bus0.data_out), 32'h00AA);
    chk("both_full_valid", 32'(bus0.rd_valid), 1);

    // flush beats simultaneous write/read
    bus0.flush = 1'b1;
    tick();
    chk("flush_count", 32'(bus0.count), 0);
    chk("flush_empty", 32'(bus0.empty), 1);
    chk("flush_valid", 32'(bus0.rd_valid), 0);
    chk("flush_ack", 32'(bus0.wr_ack), 0);
    chk("flush_data_hold", 32'(bus0.data_out), 32'h00AA);
    idle0();

    // wrap-around: 20 write-then-read pairs
    for (int i = 0; i < 20; i++) begin
      bus0.wr_en = 1'b1; bus0.rd_en = 1'b0; bus0.data_in = 16'(i);
      tick();
      bus0.wr_en = 1'b0; bus0.rd_en = 1'b1;
      tick();
      chk("wrap_data", 32'(bus0.data_out), 32'(i));
      chk("wrap_valid", 32'(bus0.rd_valid), 1);
      chk("wrap_ptr_range",
          32'((dut0.wr_ptr_q < 3'd6) && (dut0.rd_ptr_q < 3'd6)), 1);
    end
    idle0();

    // FWFT: zero-latency presentation
    bus1.wr_en = 1'b1; bus1.data_in = 16'hBEEF;
    tick();
    bus1.wr_en = 1'b0;
    chk("fwft_data", 32'(bus1.data_out), 32'hBEEF);
    chk("fwft_valid", 32'(bus1.rd_valid), 1);
    bus1.flush = 1'b1; bus1.wr_en = 1'b1; bus1.data_in = 16'h1234;
    tick();
    bus1.flush = 1'b0; bus1.wr_en = 1'b0;
    chk("fwft_flush_count", 32'(bus1.count), 0);
    chk("fwft_flush_valid", 32'(bus1.rd_valid), 0);
    chk("fwft_flush_ack", 32'(bus1.wr_ack), 0);
    for (int i = 1; i <= 3; i++) begin
      bus1.wr_en = 1'b1; bus1.data_in = 16'(16'h0011 * i);
      tick();
    end
    bus1.wr_en = 1'b0;
    chk("fwft_head", 32'(bus1.data_out), 32'h0011);
    chk("fwft_count3", 32'(bus1.count), 3);
    bus1.rd_en = 1'b1;
    tick();
    bus1.rd_en = 1'b0;
    chk("fwft_pop", 32'(bus1.data_out), 32'h0022);
    bus1.wr_en = 1'b1; bus1.data_in = 16'h0044;
    tick();
    bus1.wr_en = 1'b0;
    chk("fwft_prerst_count", 32'(bus1.count), 3);

    // reset mid-fill
    rst_n = 1'b0;
    tick();
    chk("fwft_rst_count", 32'(bus1.count), 0);
    chk("fwft_rst_empty", 32'(bus1.empty), 1);
    chk("fwft_rst_full", 32'(bus1.full), 0);
    chk("fwft_rst_af", 32'(bus1.almostfull), 0);
    chk("fwft_rst_ae", 32'(bus1.almostempty), 1);
    chk("fwft_rst_ack", 32'(bus1.wr_ack), 0);
    chk("fwft_rst_ovf", 32'(bus1.overflow), 0);
    chk("fwft_rst_udf", 32'(bus1.underflow), 0);
    chk("fwft_rst_valid", 32'(bus1.rd_valid), 0);
    chk("fwft_rst_data", 32'(bus1.data_out), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
